serial_byte_receiver: RTL

- Serial-in/parallel-out receiver. It is the receive end of the 8-bit right-shifting shifter chain: it takes the bit stream from the shifter's LSB output and rebuilds the parallel word.
- A start pulse arms it. It then samples serial_in on each bit_valid strobe, counts WIDTH bits, and presents the word on a valid/ready handshake.
- It detects overrun (bits arriving while a word is held) and supports abort.

---
 rtl/serial_rx_pkg.sv | 19 +
 rtl/rx_shift_reg.sv | 33 +++
 rtl/serial_byte_receiver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receive path: state encoding, default word
// width (common with the transmitter shifter) and bit-counter sizing.
package serial_rx_pkg;

  localparam int unsigned RX_WIDTH = 8;

  function automatic int unsigned rx_cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned RX_CNT_W = rx_cnt_width(RX_WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_shift_reg.sv
// Serial-in shift register for the receiver; bit order selected by MSB_FIRST
// (0: first bit ends in bit 0, matching a right-shifting transmitter).
module rx_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  assign w_next = (MSB_FIRST != 0) ? {r_q[WIDTH-2:0], bit_in}
                                   : {bit_in, r_q[WIDTH-1:1]};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (clear) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/serial_byte_receiver.sv
// Serial-to-parallel receiver: armed by start, samples serial_in on bit_valid,
// presents each completed word on a valid/ready handshake with sticky overrun.
module serial_byte_receiver
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH     = RX_WIDTH,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              serial_in,
  input  logic                              bit_valid,
  input  logic                              data_ready,
  output logic [WIDTH-1:0]                  data_out,
  output logic                              data_valid,
  output logic                              busy,
  output logic [rx_cnt_width(WIDTH)-1:0]    bit_count,
  output logic                              overrun
);

  localparam int unsigned CNT_W = rx_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  rx_state_t        r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_sreg;
  logic [WIDTH-1:0] w_shifted;
  logic             w_clear;
  logic             w_shift;

  // A start is accepted in IDLE, in COLLECT (restart) and in HOLD only with a handshake.
  always_comb begin
    w_clear = 1'b0;
    w_shift = 1'b0;
    if (!abort) begin
      unique case (r_state)
        IDLE:    w_clear = start;
        COLLECT: begin
          w_clear = start;
          w_shift = bit_valid && !start;
        end
        HOLD:    w_clear = start && data_ready;
        default: w_clear = 1'b0;
      endcase
    end
  end

  rx_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sreg (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (w_clear),
    .shift_en (w_shift),
    .bit_in   (serial_in),
    .q        (w_sreg)
  );

  // Same shift as the sub-module, so the completing bit lands in data_out this edge.
  assign w_shifted = (MSB_FIRST != 0) ? {w_sreg[WIDTH-2:0], serial_in}
                                      : {serial_in, w_sreg[WIDTH-1:1]};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!abort && start) begin
            r_state   <= COLLECT;
            r_count   <= '0;
            r_overrun <= 1'b0;
          end
        end
        COLLECT: begin
          if (abort) begin
            r_state <= IDLE;
            r_count <= '0;
          end else if (start) begin
            r_count <= '0;
          end else if (bit_valid) begin
            if (r_count == LAST_IDX) begin
              r_data  <= w_shifted;
              r_state <= HOLD;
              r_valid <= 1'b1;
              r_count <= FULL_CNT;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_count <= '0;
          end else if (start && data_ready) begin
            r_state   <= COLLECT;
            r_valid   <= 1'b0;
            r_count   <= '0;
            r_overrun <= 1'b0;
          end else begin
            if (data_ready) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_count <= '0;
            end
            if (bit_valid && !start) begin
              r_overrun <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_count <= '0;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign busy       = (r_state != IDLE);
  assign bit_count  = r_count;
  assign overrun    = r_overrun;

endmodule
